// File: rtl/risc_pkg.sv
// Shared constants for the risc_cpu memory subsystem.
//   AWIDTH / DWIDTH : program/data memory geometry (32 x 8)
//   IDLE/XFER/ACK   : mem_port_arbiter state encoding
//   CPU / HOST      : requester IDs, also the bit index into request vectors
package risc_pkg;

  localparam int unsigned AWIDTH = 5;
  localparam int unsigned DWIDTH = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  localparam logic CPU  = 1'b0;
  localparam logic HOST = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU port, the host/loader port, the single-port
// memory and mem_port_arbiter.
//   cpu_*   : CPU request/response (req, wr, addr, wdata / rdata, ack, stall)
//   host_*  : host request/response (req, wr, addr, wdata / rdata, ack), lock
//   mem_*   : memory side (addr, wr, wdata / rdata)
// Modports:
//   master : requesters and memory model (drive requests, memory read data)
//   slave  : the arbiter (drives responses and the memory strobes)
interface mem_port_arbiter_if #(
  parameter int unsigned AWIDTH = risc_pkg::AWIDTH,
  parameter int unsigned DWIDTH = risc_pkg::DWIDTH
);

  logic              cpu_req;
  logic              cpu_wr;
  logic [AWIDTH-1:0] cpu_addr;
  logic [DWIDTH-1:0] cpu_wdata;
  logic [DWIDTH-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              host_req;
  logic              host_wr;
  logic [AWIDTH-1:0] host_addr;
  logic [DWIDTH-1:0] host_wdata;
  logic [DWIDTH-1:0] host_rdata;
  logic              host_ack;
  logic              host_lock;

  logic [AWIDTH-1:0] mem_addr;
  logic              mem_wr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output host_req, host_wr, host_addr, host_wdata, host_lock,
    input  host_rdata, host_ack,
    input  mem_addr, mem_wr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  host_req, host_wr, host_addr, host_wdata, host_lock,
    output host_rdata, host_ack,
    output mem_addr, mem_wr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
//   req[1:0]  : request vector indexed by requester ID (CPU=0, HOST=1)
//   last      : ID granted most recently
//   gnt_valid : at least one request present
//   gnt_id    : chosen ID; on a tie the requester that is not 'last'
module rr_pick2
  import risc_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = CPU;
    if (&req) begin
      gnt_id = ~last;
    end else if (req[HOST]) begin
      gnt_id = HOST;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port 32x8 program/data memory between the CPU datapath
// and the host/loader port. One access per IDLE -> XFER -> ACK sequence;
// ties are broken round-robin and host_lock keeps the CPU out of arbitration.
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : mem_port_arbiter_if.slave (CPU port, host port, memory port)
module mem_port_arbiter #(
  parameter int unsigned AWIDTH = risc_pkg::AWIDTH,
  parameter int unsigned DWIDTH = risc_pkg::DWIDTH
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  import risc_pkg::*;

  logic [1:0]        state;
  logic              last_grant;
  logic              gnt_id;
  logic [AWIDTH-1:0] lat_addr;
  logic              lat_wr;
  logic [DWIDTH-1:0] lat_wdata;
  logic [DWIDTH-1:0] cpu_rdata_q;
  logic [DWIDTH-1:0] host_rdata_q;

  logic [1:0]        req;
  logic              pick_valid;
  logic              pick_id;

  always_comb begin
    req       = '0;
    req[CPU]  = bus.cpu_req & ~bus.host_lock;
    req[HOST] = bus.host_req;
  end

  rr_pick2 u_pick (
    .req       (req),
    .last      (last_grant),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant   <= HOST;
      gnt_id       <= CPU;
      lat_addr     <= '0;
      lat_wr       <= 1'b0;
      lat_wdata    <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt_id     <= pick_id;
            last_grant <= pick_id;
            if (pick_id == HOST) begin
              lat_addr  <= bus.host_addr;
              lat_wr    <= bus.host_wr;
              lat_wdata <= bus.host_wdata;
            end else begin
              lat_addr  <= bus.cpu_addr;
              lat_wr    <= bus.cpu_wr;
              lat_wdata <= bus.cpu_wdata;
            end
            state <= XFER;
          end
        end
        XFER: begin
          // Captured for writes too: returns the pre-write contents.
          if (gnt_id == HOST) begin
            host_rdata_q <= bus.mem_rdata;
          end else begin
            cpu_rdata_q <= bus.mem_rdata;
          end
          state <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobe and acks decode from state so an async reset drops them at once.
  assign bus.mem_addr   = lat_addr;
  assign bus.mem_wdata  = lat_wdata;
  assign bus.mem_wr     = (state == XFER) & lat_wr;

  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.cpu_ack    = (state == ACK) & (gnt_id == CPU);
  assign bus.host_ack   = (state == ACK) & (gnt_id == HOST);
  assign bus.cpu_stall  = bus.cpu_req & ~((gnt_id == CPU) & (state != IDLE));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a 32x8 memory model.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.AWIDTH(5), .DWIDTH(8)) bus ();

  mem_port_arbiter #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: combinational read, write on rising edge; side port for preload.
  logic [7:0] mem [32] = '{default: 8'h00};
  logic       pl_en;
  logic [4:0] pl_addr;
  logic [7:0] pl_data;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // Single uncontended access from IDLE; checks every cycle of the sequence.
  task automatic do_access(input bit is_host, input bit wr, input logic [4:0] a,
                           input logic [7:0] d, input logic [7:0] exp_rd, input string tag);
    if (is_host) begin
      bus.host_req = 1'b1; bus.host_wr = wr; bus.host_addr = a; bus.host_wdata = d;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
    tick();
    check_eq({tag, ".xfer_wr"},   bus.mem_wr,   wr);
    check_eq({tag, ".xfer_addr"}, bus.mem_addr, a);
    if (wr) check_eq({tag, ".xfer_wdata"}, bus.mem_wdata, d);
    check_eq({tag, ".xfer_acks"}, {bus.cpu_ack, bus.host_ack}, 2'b00);
    tick();
    check_eq({tag, ".ack_acks"}, {bus.cpu_ack, bus.host_ack}, is_host ? 2'b01 : 2'b10);
    check_eq({tag, ".ack_wr"},   bus.mem_wr, 1'b0);
    check_eq({tag, ".rdata"},    is_host ? bus.host_rdata : bus.cpu_rdata, exp_rd);
    bus.host_req = 1'b0;
    bus.cpu_req  = 1'b0;
    tick();
    check_eq({tag, ".idle_acks"}, {bus.cpu_ack, bus.host_ack}, 2'b00);
    check_eq({tag, ".idle_wr"},   bus.mem_wr, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.host_req = 1'b0; bus.host_wr = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.host_lock = 1'b0;

    // Reset values
    #12;
    check_eq("rst.acks",   {bus.cpu_ack, bus.host_ack}, 2'b00);
    check_eq("rst.mem_wr", bus.mem_wr, 1'b0);
    check_eq("rst.addr",   bus.mem_addr, 5'd0);
    check_eq("rst.wdata",  bus.mem_wdata, 8'h00);
    check_eq("rst.rdata",  {bus.cpu_rdata, bus.host_rdata}, 16'h0000);
    check_eq("rst.stall0", bus.cpu_stall, 1'b0);
    bus.cpu_req = 1'b1;
    #1;
    check_eq("rst.stall1", bus.cpu_stall, 1'b1);
    bus.cpu_req = 1'b0;
    tick();
    rst = 1'b1;

    preload(5'd3, 8'h3C);
    preload(5'd7, 8'h70);
    preload(5'd9, 8'h99);
    preload(5'd5, 8'h55);
    preload(5'd2, 8'h22);

    // Contention: CPU wins first tie after reset, then alternates
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 5'd3;
    bus.host_req = 1'b1; bus.host_wr = 1'b0; bus.host_addr = 5'd7;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("rr%0d.addr", k),  bus.mem_addr, (k % 2 == 1) ? 5'd7 : 5'd3);
      check_eq($sformatf("rr%0d.stall", k), bus.cpu_stall, (k % 2 == 1) ? 1'b1 : 1'b0);
      tick();
      check_eq($sformatf("rr%0d.acks", k), {bus.cpu_ack, bus.host_ack},
               (k % 2 == 1) ? 2'b01 : 2'b10);
      if (k % 2 == 1) check_eq($sformatf("rr%0d.hrd", k), bus.host_rdata, 8'h70);
      else            check_eq($sformatf("rr%0d.crd", k), bus.cpu_rdata, 8'h3C);
      if (k == 3) begin
        bus.cpu_req = 1'b0;
        bus.host_req = 1'b0;
      end
      tick();
      check_eq($sformatf("rr%0d.idle", k), {bus.cpu_ack, bus.host_ack, bus.mem_wr}, 3'b000);
    end

    // Host write then CPU readback
    do_access(1'b1, 1'b1, 5'd7, 8'hA5, 8'h70, "hwr7");
    check_eq("hwr7.mem", mem[7], 8'hA5);
    do_access(1'b0, 1'b0, 5'd7, 8'h00, 8'hA5, "crd7");

    // Address change during XFER is ignored
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 5'd3;
    tick();
    bus.cpu_addr = 5'd9;
    #1;
    check_eq("chg.addr", bus.mem_addr, 5'd3);
    tick();
    check_eq("chg.ack",   bus.cpu_ack, 1'b1);
    check_eq("chg.rdata", bus.cpu_rdata, 8'h3C);
    bus.cpu_req = 1'b0;
    tick();

    // Read leaves memory untouched
    do_access(1'b0, 1'b0, 5'd5, 8'hEE, 8'h55, "crd5");
    do_access(1'b1, 1'b0, 5'd5, 8'h00, 8'h55, "hrd5");

    // host_lock holds the CPU off
    bus.host_lock = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 5'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq($sformatf("lock%0d", i), {bus.cpu_ack, bus.cpu_stall, bus.mem_wr}, 3'b010);
    end
    bus.host_lock = 1'b0;
    tick();
    check_eq("unlock.stall", bus.cpu_stall, 1'b0);
    check_eq("unlock.addr",  bus.mem_addr, 5'd3);
    tick();
    check_eq("unlock.ack",   bus.cpu_ack, 1'b1);
    check_eq("unlock.rdata", bus.cpu_rdata, 8'h3C);
    bus.cpu_req = 1'b0;
    tick();

    // Reset mid-XFER of a host write
    bus.host_req = 1'b1; bus.host_wr = 1'b1; bus.host_addr = 5'd2; bus.host_wdata = 8'hFF;
    tick();
    check_eq("rx.pre_wr", bus.mem_wr, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("rx.mem_wr", bus.mem_wr, 1'b0);
    check_eq("rx.addr",   bus.mem_addr, 5'd0);
    check_eq("rx.wdata",  bus.mem_wdata, 8'h00);
    check_eq("rx.acks",   {bus.cpu_ack, bus.host_ack}, 2'b00);
    check_eq("rx.rdata",  {bus.cpu_rdata, bus.host_rdata}, 16'h0000);
    bus.host_req = 1'b0;
    tick();
    check_eq("rx.mem2", mem[2], 8'h22);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("rx.noack%0d", i), bus.host_ack, 1'b0);
    end
    do_access(1'b1, 1'b0, 5'd2, 8'h00, 8'h22, "rx.rd2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
